pipe_scoreboard: RTL and testbench



---
 rtl/mips_pipe_pkg.sv | 29 ++
 rtl/pipe_scoreboard_if.sv | 35 +++
 rtl/sb_match_prio.sv | 44 ++++
 rtl/pipe_scoreboard.sv | 109 ++++++++++
 tb/tb_pipe_scoreboard.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS pipeline hazard scoreboard.
// Optional feature macro: MIPS_PIPE_FWD_EN (operand forwarding).
package mips_pipe_pkg;

  // Widest register number the entry type can hold; narrower RW zero-extends.
  localparam int unsigned RW_MAX   = 8;
  localparam int unsigned REG_ZERO = 0;

  // Forward-select encoding: 0 = register file, k+1 = result held in entry k.
  localparam int unsigned FWD_RF   = 0;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic              load;
    logic [RW_MAX-1:0] dst;
  } sb_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;

  function automatic int unsigned fsw_of(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned fwd_sel_of(input int unsigned k);
    return k + 1;
  endfunction

endpackage

// File: rtl/pipe_scoreboard_if.sv
// ID-stage <-> scoreboard signal bundle.
// master: pipeline/ID side, slave: scoreboard.
interface pipe_scoreboard_if #(
  parameter int unsigned RW  = 5,
  parameter int unsigned SCW = 16,
  parameter int unsigned FSW = 2
);
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic          id_rs_used;
  logic          id_rt_used;
  logic [RW-1:0] id_dst;
  logic          id_we;
  logic          id_load;
  logic          flush;

  logic           stall;
  logic           issue;
  logic [FSW-1:0] fwd_a_sel;
  logic [FSW-1:0] fwd_b_sel;
  logic [SCW-1:0] stall_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_dst, id_we, id_load, flush,
    input  stall, issue, fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used,
           id_dst, id_we, id_load, flush,
    output stall, issue, fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/sb_match_prio.sv
// Priority search of scoreboard entries for one source register.
// Reports the youngest (lowest-index) matching writer and whether it is a load.
module sb_match_prio
  import mips_pipe_pkg::*;
#(
  parameter int unsigned RW    = 5,
  parameter int unsigned DEPTH = 3,
  parameter int unsigned FSW   = 2
) (
  input  sb_entry_t [DEPTH-1:0] entries,
  input  logic [RW-1:0]         src,
  input  logic                  src_used,
  output logic                  hit,
  output logic [FSW-1:0]        k,
  output logic                  is_load
);

  logic [DEPTH-1:0] match;

  // Per-entry match; register zero never creates a dependency.
  always_comb begin
    match = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      match[i] = entries[i].valid && entries[i].we &&
                 (entries[i].dst == RW_MAX'(src)) &&
                 (src != RW'(REG_ZERO)) && src_used;
    end
  end

  // Lowest matching index wins; older writers of the same register are shadowed.
  always_comb begin
    hit     = 1'b0;
    k       = '0;
    is_load = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (match[i] && !hit) begin
        hit     = 1'b1;
        k       = FSW'(i);
        is_load = entries[i].load;
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// Hazard/forwarding scoreboard for the 5-stage MIPS pipeline.
// Tracks destinations of in-flight instructions (entry 0 = EX .. DEPTH-1 = WB),
// decides stall/issue for the ID instruction and drives EX operand selects.
// Optional feature macro: MIPS_PIPE_FWD_EN (forwarding; only load-use stalls).
module pipe_scoreboard
  import mips_pipe_pkg::*;
#(
  parameter int unsigned RW         = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned FLUSH_KILL = 1,
  parameter int unsigned SCW        = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_scoreboard_if.slave sb
);

  localparam int unsigned FSW = fsw_of(DEPTH);

`ifdef MIPS_PIPE_FWD_EN
  localparam bit FWD_EN = 1'b1;
`else
  localparam bit FWD_EN = 1'b0;
`endif

  sb_entry_t [DEPTH-1:0] ent;
  sb_entry_t             id_entry;

  logic           hit_a, hit_b;
  logic           ld_a, ld_b;
  logic [FSW-1:0] k_a, k_b;
  logic           haz_a, haz_b, hazard;

  sb_match_prio #(.RW(RW), .DEPTH(DEPTH), .FSW(FSW)) u_match_a (
    .entries  (ent),
    .src      (sb.id_rs),
    .src_used (sb.id_rs_used),
    .hit      (hit_a),
    .k        (k_a),
    .is_load  (ld_a)
  );

  sb_match_prio #(.RW(RW), .DEPTH(DEPTH), .FSW(FSW)) u_match_b (
    .entries  (ent),
    .src      (sb.id_rt),
    .src_used (sb.id_rt_used),
    .hit      (hit_b),
    .k        (k_b),
    .is_load  (ld_b)
  );

  // Hazard and operand select: with forwarding only a load still short of its
  // data blocks; without it any in-flight writer blocks until it retires.
  always_comb begin
    if (FWD_EN) begin
      haz_a        = hit_a && ld_a && (32'(k_a) < LOAD_LAT);
      haz_b        = hit_b && ld_b && (32'(k_b) < LOAD_LAT);
      sb.fwd_a_sel = hit_a ? FSW'(fwd_sel_of(32'(k_a))) : FSW'(FWD_RF);
      sb.fwd_b_sel = hit_b ? FSW'(fwd_sel_of(32'(k_b))) : FSW'(FWD_RF);
    end else begin
      haz_a        = hit_a;
      haz_b        = hit_b;
      sb.fwd_a_sel = FSW'(FWD_RF);
      sb.fwd_b_sel = FSW'(FWD_RF);
    end
    hazard = haz_a || haz_b;
  end

  // Flush outranks stall: a killed ID instruction neither waits nor issues.
  always_comb begin
    sb.stall = sb.id_valid && hazard && !sb.flush;
    sb.issue = sb.id_valid && !hazard && !sb.flush;
  end

  // Entry image of the ID instruction, zero-extended to the stored width.
  always_comb begin
    id_entry       = SB_BUBBLE;
    id_entry.valid = 1'b1;
    id_entry.we    = sb.id_we;
    id_entry.load  = sb.id_load;
    id_entry.dst   = RW_MAX'(sb.id_dst);
  end

  // Entry shift register; younger entries are killed on flush as they advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent <= '0;
    end else begin
      for (int unsigned i = 1; i < DEPTH; i++) begin
        ent[i] <= ent[i-1];
        if (sb.flush && ((i - 1) < FLUSH_KILL)) begin
          ent[i].valid <= 1'b0;
        end
      end
      ent[0] <= sb.issue ? id_entry : SB_BUBBLE;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb.stall_cnt <= '0;
    end else if (sb.stall && (sb.stall_cnt != '1)) begin
      sb.stall_cnt <= sb.stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Directed, table-driven bench for pipe_scoreboard (both MIPS_PIPE_FWD_EN builds).
module tb_pipe_scoreboard;
  import mips_pipe_pkg::*;

  localparam int unsigned RW    = 5;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned SCW   = 12;
  localparam int unsigned FSW   = fsw_of(DEPTH);
  localparam int          CMAX  = (1 << SCW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_scoreboard_if #(.RW(RW), .SCW(SCW), .FSW(FSW)) bus ();

  pipe_scoreboard #(
    .RW(RW), .DEPTH(DEPTH), .LOAD_LAT(1), .FLUSH_KILL(1), .SCW(SCW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  typedef struct {
    logic v;  int rs; int rt; logic ru; logic tu;
    int dst;  logic we; logic ld; logic fl;
    logic s;  logic i;  int fa; int fb; int cnt;
  } vec_t;

  vec_t tbl[$];
  int passed = 0;
  int total  = 0;

  function automatic vec_t mk(input logic v, input int rs, input int rt,
                              input logic ru, input logic tu, input int dst,
                              input logic we, input logic ld, input logic fl,
                              input logic s, input logic i, input int fa,
                              input int fb, input int cnt);
    vec_t x;
    x.v = v; x.rs = rs; x.rt = rt; x.ru = ru; x.tu = tu;
    x.dst = dst; x.we = we; x.ld = ld; x.fl = fl;
    x.s = s; x.i = i; x.fa = fa; x.fb = fb; x.cnt = cnt;
    return x;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic apply(input vec_t x, input logic r);
    @(negedge clk);
    rst            = r;
    bus.id_valid   = x.v;
    bus.id_rs      = RW'(x.rs);
    bus.id_rt      = RW'(x.rt);
    bus.id_rs_used = x.ru;
    bus.id_rt_used = x.tu;
    bus.id_dst     = RW'(x.dst);
    bus.id_we      = x.we;
    bus.id_load    = x.ld;
    bus.flush      = x.fl;
    #1;
  endtask

  task automatic chk_row(input string tag, input vec_t x);
    chk({tag, " stall"},     int'(bus.stall),     int'(x.s));
    chk({tag, " issue"},     int'(bus.issue),     int'(x.i));
    chk({tag, " fwd_a_sel"}, int'(bus.fwd_a_sel), x.fa);
    chk({tag, " fwd_b_sel"}, int'(bus.fwd_b_sel), x.fb);
    chk({tag, " stall_cnt"}, int'(bus.stall_cnt), x.cnt);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t nop, sat, rd;
    nop = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0);

`ifdef MIPS_PIPE_FWD_EN
    tbl.push_back(mk(1, 1, 2,1,1, 3,1,0,0, 0,1,0,0,0));
    tbl.push_back(mk(1, 3, 5,1,1, 4,1,0,0, 0,1,1,0,0));
    tbl.push_back(mk(0, 0, 0,0,0, 0,0,0,0, 0,0,0,0,0));
    tbl.push_back(mk(1, 4, 3,1,1, 5,1,0,0, 0,1,2,3,0));
    tbl.push_back(mk(1, 1, 2,1,1, 0,1,0,0, 0,1,0,0,0));
    tbl.push_back(mk(1, 0, 0,1,1, 6,1,0,0, 0,1,0,0,0));
    tbl.push_back(mk(1, 6, 9,0,1, 7,1,0,0, 0,1,0,0,0));
    tbl.push_back(mk(1, 1, 0,1,0,11,1,1,0, 0,1,0,0,0));
    tbl.push_back(mk(1,11, 7,1,1,12,1,0,1, 0,0,1,2,0));
    tbl.push_back(mk(1,11, 7,1,1, 8,1,0,0, 0,1,0,3,0));
    tbl.push_back(mk(1, 1, 0,1,0, 2,1,1,0, 0,1,0,0,0));
    tbl.push_back(mk(1, 2, 7,1,1, 6,1,0,0, 1,0,1,0,0));
    tbl.push_back(mk(1, 2, 7,1,1, 6,1,0,0, 0,1,2,0,1));
    tbl.push_back(mk(1, 1, 2,1,1, 6,0,0,0, 0,1,0,3,1));
    tbl.push_back(mk(1, 6, 6,1,1, 9,1,0,0, 0,1,2,2,1));
    tbl.push_back(mk(1, 1, 0,1,0,12,1,1,0, 0,1,0,0,1));
    tbl.push_back(mk(0,12, 0,1,0, 0,0,0,0, 0,0,1,0,1));
    tbl.push_back(mk(1,12, 0,1,0,13,1,0,0, 0,1,2,0,1));
    tbl.push_back(mk(1, 1, 0,1,0,13,1,1,0, 0,1,0,0,1));
    tbl.push_back(mk(1,13, 1,1,1,14,1,0,0, 1,0,1,0,1));
    tbl.push_back(mk(1,13, 1,1,1,14,1,0,0, 0,1,2,0,2));
    sat = mk(1,3,1,1,1,3,1,1,0, 0,0,0,0,0);
`else
    tbl.push_back(mk(1, 1, 2,1,1, 3,1,0,0, 0,1,0,0,0));
    tbl.push_back(mk(1, 3, 5,1,1, 4,1,0,0, 1,0,0,0,0));
    tbl.push_back(mk(1, 3, 5,1,1, 4,1,0,0, 1,0,0,0,1));
    tbl.push_back(mk(1, 3, 5,1,1, 4,1,0,0, 1,0,0,0,2));
    tbl.push_back(mk(1, 3, 5,1,1, 4,1,0,0, 0,1,0,0,3));
    tbl.push_back(mk(1, 1, 2,1,1, 0,1,0,0, 0,1,0,0,3));
    tbl.push_back(mk(1, 0, 0,1,1, 6,1,0,0, 0,1,0,0,3));
    tbl.push_back(mk(1, 6, 9,0,1, 7,1,0,0, 0,1,0,0,3));
    tbl.push_back(mk(1, 7, 7,1,1,10,1,0,1, 0,0,0,0,3));
    tbl.push_back(mk(1, 7, 6,1,1, 8,1,0,0, 1,0,0,0,3));
    tbl.push_back(mk(1, 7, 6,1,1, 8,1,0,0, 0,1,0,0,4));
    tbl.push_back(mk(1, 1, 2,1,1, 8,0,0,0, 0,1,0,0,4));
    tbl.push_back(mk(1, 8, 1,1,1, 9,1,0,0, 1,0,0,0,4));
    tbl.push_back(mk(1, 8, 1,1,1, 9,1,0,0, 1,0,0,0,5));
    tbl.push_back(mk(1, 8, 1,1,1, 9,1,0,0, 0,1,0,0,6));
    tbl.push_back(mk(0, 9, 0,1,0, 0,0,0,0, 0,0,0,0,6));
    tbl.push_back(mk(1, 1, 0,1,0, 2,1,1,0, 0,1,0,0,6));
    tbl.push_back(mk(1, 2, 7,1,1, 6,1,0,0, 1,0,0,0,6));
    tbl.push_back(mk(1, 2, 7,1,1, 6,1,0,0, 1,0,0,0,7));
    tbl.push_back(mk(1, 2, 7,1,1, 6,1,0,0, 1,0,0,0,8));
    tbl.push_back(mk(1, 2, 7,1,1, 6,1,0,0, 0,1,0,0,9));
    sat = mk(1,3,1,1,1,3,1,0,0, 0,0,0,0,0);
`endif

    // Reset state: a valid reader of r3 sees an empty scoreboard.
    rd = mk(1,3,3,1,1,4,1,0,0, 0,1,0,0,0);
    apply(rd, 1'b1);
    chk_row("reset", rd);

    // Directed table.
    apply(nop, 1'b1);
    foreach (tbl[n]) begin
      apply(tbl[n], 1'b0);
      chk_row($sformatf("row%0d", n), tbl[n]);
    end

    // Saturation: self-dependent writer repeats issue/stall with a fixed period.
    apply(nop, 1'b1);
    for (int c = 0; c < 8400; c++) apply(sat, 1'b0);
    apply(sat, 1'b0);
    chk("sat issue", int'(bus.issue), 1);
    chk("sat cnt hold", int'(bus.stall_cnt), CMAX);
    apply(sat, 1'b1);
    chk("sat stall", int'(bus.stall), 1);
    chk("sat cnt mid-reset", int'(bus.stall_cnt), CMAX);
    apply(sat, 1'b0);
    chk("post-reset stall", int'(bus.stall), 0);
    chk("post-reset issue", int'(bus.issue), 1);
    chk("post-reset cnt", int'(bus.stall_cnt), 0);
    apply(sat, 1'b0);
    chk("restart stall", int'(bus.stall), 1);
    apply(sat, 1'b0);
    chk("restart cnt", int'(bus.stall_cnt), 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
